// File: rtl/pe_sequencer.sv
// pe_sequencer
//   Control FSM that walks one pe_dp processing element through a 4x4-filter
//   convolution over an IMG_SIZE x IMG_SIZE image. For every output window it
//   clears the accumulators, streams the 16 filter taps, stores the window sum
//   into one of four result-buffer slots, and flushes the buffer to PE memory
//   when it is full or after the last window. A file dump and a one-cycle done
//   pulse close the layer.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   start             begin a layer (sampled only while idle)
//   stall             freeze tap sequencing (honoured in MAC only)
//   busy              high from the first CLR cycle until done
//   done              one-cycle pulse after the file dump
//   rst_acc           clear the MAC accumulators (CLR)
//   acc_en            accumulate the current tap (MAC, not stalled)
//   res_buffer_en     capture the window sum into slot res_index (STORE)
//   rst_res_reg       clear the result buffer (WRITE)
//   wr_en             write the result buffer to memory word wr_adr (WRITE)
//   wr_file           trigger the memory file dump (FILE)
//   img_buffer_index  row*IMG_SIZE + col of the current window's top-left pixel
//   buffer_cntr       tap index 0..15
//   res_index         result-buffer slot 0..3
//   wr_adr            memory word address
//
// All outputs are registered: they are computed from the state being entered,
// so each control is valid for the whole cycle of its state.
module pe_sequencer #(
  parameter int IMG_SIZE     = 16,
  parameter int STRIDE       = 1,
  parameter int MAX_MEM_SIZE = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       rst_acc,
  output logic       acc_en,
  output logic       res_buffer_en,
  output logic       rst_res_reg,
  output logic       wr_en,
  output logic       wr_file,
  output logic [7:0] img_buffer_index,
  output logic [7:0] buffer_cntr,
  output logic [7:0] res_index,
  output logic [7:0] wr_adr
);

  localparam int OUT_DIM   = (IMG_SIZE - 4) / STRIDE + 1;
  localparam int NUM_WORDS = (OUT_DIM * OUT_DIM + 3) / 4;
  localparam int LAST_POS  = (OUT_DIM - 1) * STRIDE;
  localparam int COL_LIMIT = IMG_SIZE - 4;

  localparam logic [7:0] LAST_POS_C  = 8'(LAST_POS);
  localparam logic [8:0] COL_LIMIT_C = 9'(COL_LIMIT);
  localparam logic [8:0] STRIDE_W_C  = 9'(STRIDE);
  localparam logic [7:0] STRIDE_C    = 8'(STRIDE);
  localparam logic [7:0] IMG_SIZE_C  = 8'(IMG_SIZE);

  // Parameter sanity: results must fit the PE memory, indices must fit 8 bits.
  generate
    if (NUM_WORDS > MAX_MEM_SIZE) begin : g_mem_too_small
      $error("pe_sequencer: %0d result words exceed MAX_MEM_SIZE %0d", NUM_WORDS, MAX_MEM_SIZE);
    end
    if ((IMG_SIZE * IMG_SIZE > 256) || (IMG_SIZE < 4) || (STRIDE < 1)) begin : g_bad_geometry
      $error("pe_sequencer: unsupported IMG_SIZE %0d / STRIDE %0d", IMG_SIZE, STRIDE);
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_MAC   = 3'd2,
    ST_STORE = 3'd3,
    ST_WRITE = 3'd4,
    ST_FILE  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t      state_r;
  logic [7:0]  row_r;
  logic [7:0]  col_r;
  logic [4:0]  tap_r;   // next tap to issue; 16 means all taps have been issued
  logic [1:0]  slot_r;
  logic [7:0]  word_r;

  logic [8:0]  col_sum_s;
  logic [7:0]  nxt_row_s;
  logic [7:0]  nxt_col_s;
  logic [7:0]  nxt_index_s;
  logic        last_win_s;

  // Next window position (column step with row wrap) and last-window detect.
  always_comb begin
    col_sum_s = {1'b0, col_r} + STRIDE_W_C;
    nxt_row_s = row_r;
    nxt_col_s = col_sum_s[7:0];
    if (col_sum_s > COL_LIMIT_C) begin
      nxt_col_s = 8'd0;
      nxt_row_s = row_r + STRIDE_C;
    end else begin
      nxt_col_s = col_sum_s[7:0];
      nxt_row_s = row_r;
    end
    nxt_index_s = nxt_row_s * IMG_SIZE_C + nxt_col_s;
    last_win_s  = (row_r == LAST_POS_C) && (col_r == LAST_POS_C);
  end

  // Sequencing FSM with counters and registered pe_dp controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= ST_IDLE;
      row_r            <= 8'd0;
      col_r            <= 8'd0;
      tap_r            <= 5'd0;
      slot_r           <= 2'd0;
      word_r           <= 8'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      rst_acc          <= 1'b0;
      acc_en           <= 1'b0;
      res_buffer_en    <= 1'b0;
      rst_res_reg      <= 1'b0;
      wr_en            <= 1'b0;
      wr_file          <= 1'b0;
      img_buffer_index <= 8'd0;
      buffer_cntr      <= 8'd0;
      res_index        <= 8'd0;
      wr_adr           <= 8'd0;
    end else begin
      // Controls are low unless the state being entered names them.
      done          <= 1'b0;
      rst_acc       <= 1'b0;
      acc_en        <= 1'b0;
      res_buffer_en <= 1'b0;
      rst_res_reg   <= 1'b0;
      wr_en         <= 1'b0;
      wr_file       <= 1'b0;
      buffer_cntr   <= 8'd0;
      res_index     <= 8'd0;
      wr_adr        <= 8'd0;

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r          <= ST_CLR;
            row_r            <= 8'd0;
            col_r            <= 8'd0;
            tap_r            <= 5'd0;
            slot_r           <= 2'd0;
            word_r           <= 8'd0;
            img_buffer_index <= 8'd0;
            busy             <= 1'b1;
            rst_acc          <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_CLR: begin
          // Tap 0 is issued on the way into MAC.
          state_r     <= ST_MAC;
          acc_en      <= 1'b1;
          buffer_cntr <= 8'd0;
          tap_r       <= 5'd1;
        end

        ST_MAC: begin
          if (stall) begin
            // Nothing issued this cycle; hold the displayed tap.
            buffer_cntr <= buffer_cntr;
          end else if (tap_r == 5'd16) begin
            state_r       <= ST_STORE;
            res_buffer_en <= 1'b1;
            res_index     <= {6'd0, slot_r};
          end else begin
            acc_en      <= 1'b1;
            buffer_cntr <= {3'd0, tap_r};
            tap_r       <= tap_r + 5'd1;
          end
        end

        ST_STORE: begin
          if ((slot_r == 2'd3) || last_win_s) begin
            state_r     <= ST_WRITE;
            wr_en       <= 1'b1;
            rst_res_reg <= 1'b1;
            wr_adr      <= word_r;
          end else begin
            state_r          <= ST_CLR;
            slot_r           <= slot_r + 2'd1;
            row_r            <= nxt_row_s;
            col_r            <= nxt_col_s;
            img_buffer_index <= nxt_index_s;
            rst_acc          <= 1'b1;
          end
        end

        ST_WRITE: begin
          word_r <= word_r + 8'd1;
          slot_r <= 2'd0;
          if (last_win_s) begin
            state_r <= ST_FILE;
            wr_file <= 1'b1;
          end else begin
            state_r          <= ST_CLR;
            row_r            <= nxt_row_s;
            col_r            <= nxt_col_s;
            img_buffer_index <= nxt_index_s;
            rst_acc          <= 1'b1;
          end
        end

        ST_FILE: begin
          state_r <= ST_DONE;
          done    <= 1'b1;
          busy    <= 1'b0;
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: three instances (default geometry,
// IMG_SIZE=10/STRIDE=2, IMG_SIZE=9/STRIDE=1) sharing clock and reset.
module tb_pe_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance 0: defaults ----------------
  logic start0, stall0, busy0, done0, rst_acc0, acc_en0, res_buffer_en0, rst_res_reg0, wr_en0, wr_file0;
  logic [7:0] img0, cntr0, resi0, adr0;

  pe_sequencer u0 (
    .clk(clk), .rst(rst), .start(start0), .stall(stall0),
    .busy(busy0), .done(done0), .rst_acc(rst_acc0), .acc_en(acc_en0),
    .res_buffer_en(res_buffer_en0), .rst_res_reg(rst_res_reg0), .wr_en(wr_en0), .wr_file(wr_file0),
    .img_buffer_index(img0), .buffer_cntr(cntr0), .res_index(resi0), .wr_adr(adr0)
  );

  // ---------------- instance 1: IMG_SIZE=10, STRIDE=2 ----------------
  logic start1, busy1, done1, rst_acc1, acc_en1, res_buffer_en1, rst_res_reg1, wr_en1, wr_file1;
  logic [7:0] img1, cntr1, resi1, adr1;

  pe_sequencer #(.IMG_SIZE(10), .STRIDE(2), .MAX_MEM_SIZE(128)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stall(1'b0),
    .busy(busy1), .done(done1), .rst_acc(rst_acc1), .acc_en(acc_en1),
    .res_buffer_en(res_buffer_en1), .rst_res_reg(rst_res_reg1), .wr_en(wr_en1), .wr_file(wr_file1),
    .img_buffer_index(img1), .buffer_cntr(cntr1), .res_index(resi1), .wr_adr(adr1)
  );

  // ---------------- instance 2: IMG_SIZE=9, STRIDE=1 ----------------
  logic start2, busy2, done2, rst_acc2, acc_en2, res_buffer_en2, rst_res_reg2, wr_en2, wr_file2;
  logic [7:0] img2, cntr2, resi2, adr2;

  pe_sequencer #(.IMG_SIZE(9), .STRIDE(1), .MAX_MEM_SIZE(128)) u2 (
    .clk(clk), .rst(rst), .start(start2), .stall(1'b0),
    .busy(busy2), .done(done2), .rst_acc(rst_acc2), .acc_en(acc_en2),
    .res_buffer_en(res_buffer_en2), .rst_res_reg(rst_res_reg2), .wr_en(wr_en2), .wr_file(wr_file2),
    .img_buffer_index(img2), .buffer_cntr(cntr2), .res_index(resi2), .wr_adr(adr2)
  );

  // Expected top-left index of window k for the default geometry (13x13 windows, 16-pixel rows).
  function automatic int exp_idx0(input int k);
    return (k / 13) * 16 + (k % 13);
  endfunction

  // ---------------- instance 0 observer ----------------
  int cyc = 0;
  logic busy0_q = 1'b0;
  int st0 = 0, wr0 = 0, fl0 = 0, dn0 = 0;
  int first_clr0 = 0, done_cyc0 = 0, last_clr0 = 0, prev_clr0 = 0;
  int exp_tap = 0, exp_slot = 0;
  int tap_err = 0, slot_err = 0, idx_err = 0, adr_err = 0;
  logic [7:0] idx13 = 8'd0, idx14 = 8'd0, lidx0 = 8'd0, ladr0 = 8'd0;

  // Per-cycle bookkeeping of instance 0 outputs, sampled mid-cycle.
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    busy0_q <= busy0;
    if (busy0 && !busy0_q) begin
      st0        <= 0;
      wr0        <= 0;
      fl0        <= 0;
      dn0        <= 0;
      first_clr0 <= cyc;
      exp_slot   <= 0;
    end else begin
      if (acc_en0) begin
        if (cntr0 != 8'(exp_tap)) tap_err <= tap_err + 1;
        exp_tap <= exp_tap + 1;
      end
      if (res_buffer_en0) begin
        if (exp_tap != 16) tap_err <= tap_err + 1;
        if (resi0 != 8'(exp_slot)) slot_err <= slot_err + 1;
        if (img0 != 8'(exp_idx0(st0))) idx_err <= idx_err + 1;
        if (st0 == 12) idx13 <= img0;
        if (st0 == 13) idx14 <= img0;
        lidx0    <= img0;
        st0      <= st0 + 1;
        exp_slot <= exp_slot + 1;
      end
      if (wr_en0) begin
        if (adr0 != 8'(wr0)) adr_err <= adr_err + 1;
        if (!((exp_slot == 4) || (st0 == 169))) slot_err <= slot_err + 1;
        ladr0    <= adr0;
        wr0      <= wr0 + 1;
        exp_slot <= 0;
      end
      if (rst_res_reg0 != wr_en0) adr_err <= adr_err + 1;
      if (wr_file0) fl0 <= fl0 + 1;
      if (done0) begin
        dn0       <= dn0 + 1;
        done_cyc0 <= cyc;
      end
    end
    if (rst_acc0) begin
      exp_tap   <= 0;
      prev_clr0 <= last_clr0;
      last_clr0 <= cyc;
    end
  end

  // ---------------- instance 1/2 observers ----------------
  logic busy1_q = 1'b0, busy2_q = 1'b0;
  int st1 = 0, wr1 = 0, fl1 = 0, err1 = 0, first_clr1 = 0, done_cyc1 = 0;
  int st2 = 0, wr2 = 0, fl2 = 0, err2 = 0, first_clr2 = 0, done_cyc2 = 0;
  logic [7:0] lidx1 = 8'd0, ladr1 = 8'd0, lidx2 = 8'd0, ladr2 = 8'd0;

  // Store/write/dump counting for instance 1.
  always @(negedge clk) begin
    busy1_q <= busy1;
    if (busy1 && !busy1_q) begin
      st1 <= 0; wr1 <= 0; fl1 <= 0; first_clr1 <= cyc;
    end else begin
      if (res_buffer_en1) begin st1 <= st1 + 1; lidx1 <= img1; end
      if (wr_en1) begin
        if ((adr1 != 8'(wr1)) || !rst_res_reg1) err1 <= err1 + 1;
        wr1 <= wr1 + 1; ladr1 <= adr1;
      end
      if (wr_file1) fl1 <= fl1 + 1;
      if (done1) done_cyc1 <= cyc;
    end
  end

  // Store/write/dump counting for instance 2.
  always @(negedge clk) begin
    busy2_q <= busy2;
    if (busy2 && !busy2_q) begin
      st2 <= 0; wr2 <= 0; fl2 <= 0; first_clr2 <= cyc;
    end else begin
      if (res_buffer_en2) begin st2 <= st2 + 1; lidx2 <= img2; end
      if (wr_en2) begin
        if ((adr2 != 8'(wr2)) || !rst_res_reg2) err2 <= err2 + 1;
        wr2 <= wr2 + 1; ladr2 <= adr2;
      end
      if (wr_file2) fl2 <= fl2 + 1;
      if (done2) done_cyc2 <= cyc;
    end
  end

  logic [39:0] outs0;
  assign outs0 = {busy0, done0, rst_acc0, acc_en0, res_buffer_en0, rst_res_reg0, wr_en0, wr_file0,
                  img0, cntr0, resi0, adr0};

  // Directed stimulus and checks.
  initial begin
    int n;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; stall0 = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("reset_outs0", 64'(outs0), 64'd0);
    check("reset_busy1", 64'(busy1), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs0", 64'(outs0), 64'd0);

    // Layer 1 on defaults, with an ignored second start mid-layer
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("start_busy", 64'(busy0), 64'd1);
    check("start_rst_acc", 64'(rst_acc0), 64'd1);
    check("start_acc_en", 64'(acc_en0), 64'd0);
    repeat (100) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 4000) begin @(negedge clk); n++; end
    #1;
    check("l1_done_seen", 64'(done0), 64'd1);
    check("l1_busy_at_done", 64'(busy0), 64'd0);
    check("l1_stores", 64'(st0), 64'd169);
    check("l1_writes", 64'(wr0), 64'd43);
    check("l1_last_adr", 64'(ladr0), 64'd42);
    check("l1_file", 64'(fl0), 64'd1);
    check("l1_latency", 64'(done_cyc0 - first_clr0), 64'd3086);
    check("l1_idx13", 64'(idx13), 64'd12);
    check("l1_idx14", 64'(idx14), 64'd16);
    check("l1_idx_last", 64'(lidx0), 64'd204);
    check("l1_tap_err", 64'(tap_err), 64'd0);
    check("l1_slot_err", 64'(slot_err), 64'd0);
    check("l1_idx_err", 64'(idx_err), 64'd0);
    check("l1_adr_err", 64'(adr_err), 64'd0);
    @(negedge clk);
    check("l1_done_pulse", 64'({done0, busy0}), 64'd0);

    // Layer 2 on defaults: stall at tap 7, then reset mid-MAC
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!(acc_en0 && cntr0 == 8'd7) && n < 50) begin @(negedge clk); n++; end
    check("stall_reach_tap7", 64'({acc_en0, cntr0}), 64'h107);
    stall0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({acc_en0, cntr0}), 64'h007);
    end
    stall0 = 1'b0;
    @(negedge clk);
    check("stall_resume", 64'({acc_en0, cntr0}), 64'h108);
    n = 0;
    while (!rst_acc0 && n < 50) begin @(negedge clk); n++; end
    #1;
    check("stall_window_len", 64'(last_clr0 - prev_clr0), 64'd23);
    check("stall_tap_err", 64'(tap_err), 64'd0);
    n = 0;
    while (!(acc_en0 && cntr0 == 8'd4) && n < 50) begin @(negedge clk); n++; end
    check("midmac_reach", 64'(acc_en0), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("midmac_reset_outs", 64'(outs0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    check("post_reset_writes", 64'(wr0), 64'd0);
    check("post_reset_file", 64'(fl0), 64'd0);
    check("post_reset_done", 64'(dn0), 64'd0);
    check("post_reset_outs", 64'(outs0), 64'd0);

    // Instance 1: start held high through the layer, restart after done
    @(negedge clk);
    start1 = 1'b1;
    n = 0;
    while (!done1 && n < 1000) begin @(negedge clk); n++; end
    #1;
    check("u1_done_seen", 64'(done1), 64'd1);
    check("u1_stores", 64'(st1), 64'd16);
    check("u1_writes", 64'(wr1), 64'd4);
    check("u1_last_adr", 64'(ladr1), 64'd3);
    check("u1_file", 64'(fl1), 64'd1);
    check("u1_idx_last", 64'(lidx1), 64'd66);
    check("u1_latency", 64'(done_cyc1 - first_clr1), 64'd293);
    check("u1_err", 64'(err1), 64'd0);
    @(negedge clk);
    check("u1_idle_after_done", 64'(busy1), 64'd0);
    @(negedge clk);
    check("u1_restart_busy", 64'({busy1, rst_acc1}), 64'd3);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 1000) begin @(negedge clk); n++; end
    #1;
    check("u1_second_stores", 64'(st1), 64'd16);
    check("u1_second_writes", 64'(wr1), 64'd4);

    // Instance 2: start pulse, second start while busy is ignored
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (50) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 2000) begin @(negedge clk); n++; end
    #1;
    check("u2_done_seen", 64'(done2), 64'd1);
    check("u2_stores", 64'(st2), 64'd36);
    check("u2_writes", 64'(wr2), 64'd9);
    check("u2_last_adr", 64'(ladr2), 64'd8);
    check("u2_file", 64'(fl2), 64'd1);
    check("u2_idx_last", 64'(lidx2), 64'd50);
    check("u2_latency", 64'(done_cyc2 - first_clr2), 64'd658);
    check("u2_err", 64'(err2), 64'd0);
    repeat (3) @(negedge clk);
    check("u2_no_restart", 64'(busy2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
